pdu_uart_mmio_sched: RTL and testbench

//  Hardware master for the PDU UART register port: shares the single MMIO port between a TX byte stream and an RX byte stream.

---
 rtl/pdu_uart_mmio_sched_if.sv | 23 ++
 rtl/pdu_uart_mmio_sched.sv | 201 ++++++++++++++++++++
 tb/tb_pdu_uart_mmio_sched.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdu_uart_mmio_sched_if.sv
// MMIO bus between the UART scheduler (master) and the UART register block (slave).
// One access per cycle: mmio_we=1 is a write of mmio_wdata to mmio_addr,
// mmio_we=0 is a read whose data comes back combinationally on mmio_rdata.
interface pdu_uart_mmio_sched_if;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic        mmio_we;
    logic [31:0] mmio_rdata;

    modport master (
        output mmio_addr,
        output mmio_wdata,
        output mmio_we,
        input  mmio_rdata
    );

    modport slave (
        input  mmio_addr,
        input  mmio_wdata,
        input  mmio_we,
        output mmio_rdata
    );
endinterface

// File: rtl/pdu_uart_mmio_sched.sv
// PDU UART register-port master: shares one MMIO port between a TX byte stream
// and an RX byte stream and runs the UART register handshakes for both.
//
// Handshakes: a byte moves on tx (requester -> scheduler) or rx
// (scheduler -> consumer) in exactly the cycles where valid & ready are both 1
// at the rising clock edge. tx_ready is only raised in IDLE when TX wins
// arbitration and depends combinationally on tx_valid; rx_valid holds the byte
// stable until rx_ready takes it.
module pdu_uart_mmio_sched #(
    parameter logic [31:0] UART_BASE   = 32'h0000_8000,
    parameter int          ACK_TIMEOUT = 1024,
    parameter int          RX_POLL_GAP = 16
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         tx_valid,
    input  logic [7:0]                   tx_data,
    output logic                         tx_ready,
    output logic                         tx_err,
    output logic                         rx_valid,
    output logic [7:0]                   rx_data,
    input  logic                         rx_ready,
    pdu_uart_mmio_sched_if.master        mmio,
    output logic                         busy,
    output logic [3:0]                   state_dbg
);

    localparam logic [31:0] OFF_RX_RDY  = 32'h00;
    localparam logic [31:0] OFF_RX_DATA = 32'h04;
    localparam logic [31:0] OFF_RX_ACK  = 32'h08;
    localparam logic [31:0] OFF_TX_ACK  = 32'h10;
    localparam logic [31:0] OFF_TX_DATA = 32'h14;
    localparam logic [31:0] OFF_TX_RDY  = 32'h18;

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(RX_POLL_GAP + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(ACK_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RX_POLL_GAP - 1);

    typedef enum logic [3:0] {
        S_INIT_TX, S_INIT_RX, S_IDLE,
        S_TX_WR, S_TX_SET, S_TX_POLL, S_TX_CLR,
        S_RX_POLL, S_RX_RD, S_RX_SET, S_RX_CLR
    } state_t;

    state_t            state, state_next;
    logic [7:0]        tx_buf;
    logic              last_grant_rx;
    logic [GAP_W-1:0]  poll_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              grant_tx, grant_rx, tmo_fire;
    logic              unused_rdata;

    // Only bits [7:0] of a read carry meaning for this block.
    assign unused_rdata = ^mmio.mmio_rdata[31:8];

    // Arbitration in IDLE: alternate on a tie, otherwise the lone requester wins.
    always_comb begin
        grant_tx = 1'b0;
        grant_rx = 1'b0;
        if (state == S_IDLE) begin
            if (tx_valid && !rx_valid && poll_cnt == '0) begin
                grant_tx = last_grant_rx;
                grant_rx = !last_grant_rx;
            end else begin
                grant_tx = tx_valid;
                grant_rx = !rx_valid && poll_cnt == '0;
            end
        end
    end

    // Next state and Moore-decoded MMIO access for the current state.
    always_comb begin
        state_next      = state;
        mmio.mmio_addr  = UART_BASE + OFF_RX_RDY;
        mmio.mmio_wdata = 32'h0;
        mmio.mmio_we    = 1'b0;
        tmo_fire        = 1'b0;
        case (state)
            S_INIT_TX: begin
                mmio.mmio_addr = UART_BASE + OFF_TX_RDY;
                mmio.mmio_we   = 1'b1;
                state_next     = S_INIT_RX;
            end
            S_INIT_RX: begin
                mmio.mmio_addr = UART_BASE + OFF_RX_ACK;
                mmio.mmio_we   = 1'b1;
                state_next     = S_IDLE;
            end
            S_IDLE: begin
                if (grant_tx)      state_next = S_TX_WR;
                else if (grant_rx) state_next = S_RX_POLL;
            end
            S_TX_WR: begin
                mmio.mmio_addr  = UART_BASE + OFF_TX_DATA;
                mmio.mmio_wdata = {24'h0, tx_buf};
                mmio.mmio_we    = 1'b1;
                state_next      = S_TX_SET;
            end
            S_TX_SET: begin
                mmio.mmio_addr  = UART_BASE + OFF_TX_RDY;
                mmio.mmio_wdata = 32'h1;
                mmio.mmio_we    = 1'b1;
                state_next      = S_TX_POLL;
            end
            S_TX_POLL: begin
                mmio.mmio_addr = UART_BASE + OFF_TX_ACK;
                if (mmio.mmio_rdata[0]) begin
                    state_next = S_TX_CLR;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_fire   = 1'b1;
                    state_next = S_TX_CLR;
                end
            end
            S_TX_CLR: begin
                mmio.mmio_addr = UART_BASE + OFF_TX_RDY;
                mmio.mmio_we   = 1'b1;
                state_next     = S_IDLE;
            end
            S_RX_POLL: begin
                state_next = mmio.mmio_rdata[0] ? S_RX_RD : S_IDLE;
            end
            S_RX_RD: begin
                mmio.mmio_addr = UART_BASE + OFF_RX_DATA;
                state_next     = S_RX_SET;
            end
            S_RX_SET: begin
                mmio.mmio_addr  = UART_BASE + OFF_RX_ACK;
                mmio.mmio_wdata = 32'h1;
                mmio.mmio_we    = 1'b1;
                state_next      = S_RX_CLR;
            end
            S_RX_CLR: begin
                mmio.mmio_addr = UART_BASE + OFF_RX_ACK;
                mmio.mmio_we   = 1'b1;
                state_next     = S_IDLE;
            end
            default: state_next = S_INIT_TX;
        endcase
    end

    // State register; reset restarts with the INIT writes that clear stale UART handshake bits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_INIT_TX;
        else            state <= state_next;
    end

    // Accepted TX byte and the fairness bit; empty RX polls also count as RX grants.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_buf        <= 8'h00;
            last_grant_rx <= 1'b1;
        end else begin
            if (grant_tx) begin
                tx_buf        <= tx_data;
                last_grant_rx <= 1'b0;
            end else if (grant_rx) begin
                last_grant_rx <= 1'b1;
            end
        end
    end

    // RX poll spacing: reload after an empty poll, count down to zero every cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                                       poll_cnt <= '0;
        else if (state == S_RX_POLL && !mmio.mmio_rdata[0])   poll_cnt <= GAP_LOAD;
        else if (poll_cnt != '0)                              poll_cnt <= poll_cnt - 1'b1;
    end

    // TX_ACK wait counter: cleared entering TX_SET, saturating count of TX_POLL cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                                  tmo_cnt <= '0;
        else if (state_next == S_TX_SET)                 tmo_cnt <= '0;
        else if (state == S_TX_POLL && tmo_cnt != TMO_SAT) tmo_cnt <= tmo_cnt + 1'b1;
    end

    // One-cycle drop pulse, visible in the TX_CLR cycle that follows the last failed poll.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) tx_err <= 1'b0;
        else            tx_err <= tmo_fire;
    end

    // Received byte holding register; RX is not eligible while it is full.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else if (state == S_RX_RD) begin
            rx_valid <= 1'b1;
            rx_data  <= mmio.mmio_rdata[7:0];
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    assign tx_ready  = grant_tx;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_pdu_uart_mmio_sched.sv
// Bench for pdu_uart_mmio_sched: behavioural UART register model, cycle tables,
// directed corner sequences, randomized traffic with byte scoreboards.
module tb_pdu_uart_mmio_sched;
    localparam int TB_ACK = 8;
    localparam int TB_GAP = 4;
    localparam logic [31:0] A_RXRDY = 32'h8000;
    localparam logic [31:0] A_RXDAT = 32'h8004;
    localparam logic [31:0] A_RXACK = 32'h8008;
    localparam logic [31:0] A_TXACK = 32'h8010;
    localparam logic [31:0] A_TXDAT = 32'h8014;
    localparam logic [31:0] A_TXRDY = 32'h8018;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic sys_rst_n;
    always #5 clk = ~clk;

    logic       tx_valid, tx_ready, tx_err, rx_valid, rx_ready, busy;
    logic [7:0] tx_data, rx_data;
    logic [3:0] state_dbg;

    pdu_uart_mmio_sched_if bus ();

    pdu_uart_mmio_sched #(.UART_BASE(32'h8000), .ACK_TIMEOUT(TB_ACK), .RX_POLL_GAP(TB_GAP)) dut (
        .sys_clk(clk), .sys_rst_n(sys_rst_n),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_err(tx_err),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .mmio(bus.master), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    int err_seen = 0;
    int model_err_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- UART register model ----------------
    logic [7:0] m_rx_q[$];
    logic [7:0] m_rx_head = 8'h00;
    int         m_rx_cnt = 0;
    logic       m_rx_ack = 1'b0;
    logic [7:0] m_tx_byte = 8'h00;
    logic       m_tx_rdy = 1'b0;
    logic       m_tx_noack = 1'b0;
    int         m_ack_cnt = 0;
    int         ack_lat = 0;
    logic       ack_never = 1'b0;
    logic [7:0] dummy;

    always_comb begin
        bus.mmio_rdata = 32'h0;
        case (bus.mmio_addr)
            A_RXRDY: bus.mmio_rdata = {31'h0, (m_rx_cnt != 0) && !m_rx_ack};
            A_RXDAT: bus.mmio_rdata = {24'h0, m_rx_head};
            A_TXACK: bus.mmio_rdata = {31'h0, m_tx_rdy && (m_ack_cnt == 0) && !m_tx_noack};
            default: bus.mmio_rdata = 32'h0;
        endcase
    end

    task automatic refresh_model();
        m_rx_cnt  = m_rx_q.size();
        m_rx_head = (m_rx_q.size() != 0) ? m_rx_q[0] : 8'h00;
    endtask

    task automatic inject(input logic [7:0] b);
        m_rx_q.push_back(b);
        rx_exp_q.push_back(b);
        refresh_model();
    endtask

    // Writes take effect mid-cycle so the next cycle's reads see them.
    always @(negedge clk) begin
        if (m_ack_cnt > 0) m_ack_cnt = m_ack_cnt - 1;
        if (bus.mmio_we) begin
            case (bus.mmio_addr)
                A_TXDAT: m_tx_byte = bus.mmio_wdata[7:0];
                A_TXRDY: begin
                    if (bus.mmio_wdata[0]) begin
                        m_tx_rdy   = 1'b1;
                        m_ack_cnt  = ack_lat;
                        m_tx_noack = ack_never;
                        if (ack_never) model_err_exp++;
                        check("tx_byte_pending", {31'h0, tx_exp_q.size() != 0}, 32'h1);
                        if (tx_exp_q.size() != 0) check("tx_byte", {24'h0, m_tx_byte}, {24'h0, tx_exp_q.pop_front()});
                    end else begin
                        m_tx_rdy = 1'b0;
                    end
                end
                A_RXACK: begin
                    if (bus.mmio_wdata[0]) begin
                        if (!m_rx_ack && m_rx_q.size() != 0) dummy = m_rx_q.pop_front();
                        m_rx_ack = 1'b1;
                    end else begin
                        m_rx_ack = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        refresh_model();
    end

    // ---------------- handshake monitor ----------------
    always @(negedge clk) begin
        #2;
        if (sys_rst_n) begin
            if (tx_valid && tx_ready) tx_exp_q.push_back(tx_data);
            if (rx_valid && rx_ready) begin
                check("rx_byte_expected", {31'h0, rx_exp_q.size() != 0}, 32'h1);
                if (rx_exp_q.size() != 0) check("rx_byte", {24'h0, rx_data}, {24'h0, rx_exp_q.pop_front()});
            end
            if (tx_err) begin
                err_seen++;
                check("tx_err_cause", {31'h0, m_tx_noack}, 32'h1);
            end
            if (!bus.mmio_we) check("read_wdata_zero", bus.mmio_wdata, 32'h0);
            if (!bus.mmio_we && bus.mmio_addr == A_RXDAT) check("rx_no_overwrite", {31'h0, rx_valid}, 32'h0);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        tv;
        logic [7:0]  td;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic        rdy;
        logic        bsy;
    } vec_t;
    vec_t vecs[21];

    task automatic reset_mid_cycle(input string tag);
        #3;
        sys_rst_n = 1'b0;
        tx_valid  = 1'b1;
        rx_ready  = 1'b0;
        #1;
        check({tag, "_busy"}, {31'h0, busy}, 32'h1);
        check({tag, "_addr"}, bus.mmio_addr, A_TXRDY);
        check({tag, "_we"}, {31'h0, bus.mmio_we}, 32'h1);
        check({tag, "_wdata"}, bus.mmio_wdata, 32'h0);
        check({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'h0);
        check({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'h0);
        check({tag, "_rx_data"}, {24'h0, rx_data}, 32'h0);
        check({tag, "_tx_err"}, {31'h0, tx_err}, 32'h0);
        tx_exp_q.delete();
        rx_exp_q.delete();
        m_rx_q.delete();
        refresh_model();
        @(negedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
        tx_valid  = 1'b0;
        #1;
        check({tag, "_init_tx"}, bus.mmio_addr, A_TXRDY);
        @(negedge clk); #1;
        check({tag, "_init_rx"}, bus.mmio_addr, A_RXACK);
        check({tag, "_init_rx_we"}, {31'h0, bus.mmio_we}, 32'h1);
        @(negedge clk); #1;
        check({tag, "_idle"}, {31'h0, busy}, 32'h0);
        check({tag, "_uart_rx_ack_clear"}, {31'h0, m_rx_ack}, 32'h0);
        check({tag, "_uart_tx_rdy_clear"}, {31'h0, m_tx_rdy}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found, tx_acc;
        int          n, busy_cnt, e0, x0;
        logic [31:0] prev_addr;
        logic        prev_busy;
        int          ev[$];

        for (int i = 0; i < 21; i++) vecs[i] = '{1'b0, 8'h5A, A_RXRDY, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[0]  = '{1'b0, 8'h5A, A_TXRDY, 1'b1, 32'h0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 8'h5A, A_RXACK, 1'b1, 32'h0, 1'b0, 1'b1};
        vecs[3].bsy  = 1'b1;
        vecs[8].bsy  = 1'b1;
        vecs[13].bsy = 1'b1;
        vecs[14] = '{1'b1, 8'h5A, A_RXRDY, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h5A, A_TXDAT, 1'b1, 32'h5A, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 8'h5A, A_TXRDY, 1'b1, 32'h1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 8'h5A, A_TXACK, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 8'h5A, A_TXRDY, 1'b1, 32'h0, 1'b0, 1'b1};
        vecs[20].bsy = 1'b1;

        sys_rst_n = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = 8'h5A;
        rx_ready  = 1'b0;
        tx_acc    = 1'b0;
        #1 sys_rst_n = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        check("rst_tx_ready", {31'h0, tx_ready}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h1);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_tx_err", {31'h0, tx_err}, 32'h0);
        check("rst_addr", bus.mmio_addr, A_TXRDY);

        // Cycle table: INIT, idle polling, one TX with immediate ACK
        @(negedge clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge clk);
            tx_valid = vecs[i].tv;
            tx_data  = vecs[i].td;
            #1;
            check($sformatf("vec%0d_addr", i), bus.mmio_addr, vecs[i].addr);
            check($sformatf("vec%0d_we", i), {31'h0, bus.mmio_we}, {31'h0, vecs[i].we});
            check($sformatf("vec%0d_wdata", i), bus.mmio_wdata, vecs[i].wd);
            check($sformatf("vec%0d_tx_ready", i), {31'h0, tx_ready}, {31'h0, vecs[i].rdy});
            check($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].bsy});
            check($sformatf("vec%0d_tx_err", i), {31'h0, tx_err}, 32'h0);
        end

        // TX_ACK never arrives: drop after ACK_TIMEOUT polls
        ack_never = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = 8'h77;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk); #1;
            if (tx_ready) found = 1'b1;
        end
        check("tmo_accept_seen", {31'h0, found}, 32'h1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            #1;
            if (bus.mmio_addr == A_TXACK) found = 1'b1;
        end
        check("tmo_poll_entry_seen", {31'h0, found}, 32'h1);
        n = 0;
        while (!tx_err && n < 4 * TB_ACK) begin
            @(negedge clk); #1;
            n++;
        end
        check("tmo_err_latency", n, TB_ACK);
        check("tmo_clr_addr", bus.mmio_addr, A_TXRDY);
        check("tmo_clr_we", {31'h0, bus.mmio_we}, 32'h1);
        check("tmo_clr_wdata", bus.mmio_wdata, 32'h0);
        @(negedge clk); #1;
        check("tmo_err_single_pulse", {31'h0, tx_err}, 32'h0);
        check("tmo_back_idle", {31'h0, busy}, 32'h0);
        ack_never = 1'b0;

        // RX byte C3 held until consumer takes it
        inject(8'hC3);
        found = 1'b0;
        prev_addr = 32'h0;
        prev_busy = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk); #1;
            if (!bus.mmio_we && bus.mmio_addr == A_RXDAT) found = 1'b1;
            else begin
                prev_addr = bus.mmio_addr;
                prev_busy = busy;
            end
        end
        check("rx_read_seen", {31'h0, found}, 32'h1);
        check("rx_poll_before_read", prev_addr, A_RXRDY);
        check("rx_poll_busy", {31'h0, prev_busy}, 32'h1);
        @(negedge clk); #1;
        check("rx_set_addr", bus.mmio_addr, A_RXACK);
        check("rx_set_wdata", bus.mmio_wdata, 32'h1);
        @(negedge clk); #1;
        check("rx_clr_addr", bus.mmio_addr, A_RXACK);
        check("rx_clr_we", {31'h0, bus.mmio_we}, 32'h1);
        check("rx_clr_wdata", bus.mmio_wdata, 32'h0);
        busy_cnt = 0;
        for (int k = 0; k < 3 * (TB_GAP + 1); k++) begin
            @(negedge clk); #1;
            if (busy) busy_cnt++;
            if (k == 0 || k == 3 * TB_GAP) begin
                check("rx_hold_valid", {31'h0, rx_valid}, 32'h1);
                check("rx_hold_data", {24'h0, rx_data}, 32'hC3);
            end
        end
        check("rx_no_poll_while_held", busy_cnt, 0);
        @(negedge clk);
        rx_ready = 1'b1;
        #1 check("rx_take_valid", {31'h0, rx_valid}, 32'h1);
        @(negedge clk); #1;
        check("rx_taken_cleared", {31'h0, rx_valid}, 32'h0);

        // TX stuck high with RX bytes pending: grants alternate
        for (int k = 0; k < 4; k++) inject(8'(8'h30 + k));
        tx_valid = 1'b1;
        tx_data  = 8'(8'hA0);
        ack_lat  = 0;
        for (int k = 0; k < 200 && ev.size() < 6; k++) begin
            @(negedge clk);
            if (tx_acc) tx_data = 8'($urandom);
            #1;
            tx_acc = tx_ready;
            if (tx_ready) ev.push_back(0);
            if (!bus.mmio_we && bus.mmio_addr == A_RXDAT) ev.push_back(1);
        end
        check("alt_events_seen", ev.size(), 6);
        for (int k = 1; k < ev.size(); k++) check($sformatf("alt_order%0d", k), ev[k], 1 - ev[k-1]);
        tx_acc = 1'b0;
        tx_valid = 1'b0;

        // Randomized traffic against the UART model and byte scoreboards
        e0 = err_seen;
        x0 = model_err_exp;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (!tx_valid || tx_acc) begin
                tx_valid = ($urandom_range(0, 2) == 0);
                tx_data  = 8'($urandom);
            end
            rx_ready  = ($urandom_range(0, 3) != 0);
            ack_never = ($urandom_range(0, 9) == 0);
            ack_lat   = $urandom_range(0, TB_ACK - 2);
            if ($urandom_range(0, 11) == 0 && m_rx_q.size() < 4) inject(8'($urandom));
            #1 tx_acc = tx_valid && tx_ready;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        ack_never = 1'b0;
        for (int k = 0; k < 2000 && (rx_exp_q.size() != 0 || tx_exp_q.size() != 0 || busy || rx_valid); k++) begin
            @(negedge clk); #1;
        end
        repeat (3 * (TB_GAP + 1)) @(negedge clk);
        #1;
        check("rand_tx_drained", tx_exp_q.size(), 0);
        check("rand_rx_drained", rx_exp_q.size(), 0);
        check("rand_err_count", err_seen - e0, model_err_exp - x0);

        // Asynchronous reset during TX_POLL
        ack_never = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = 8'h11;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (tx_acc) tx_valid = 1'b0;
            #1;
            tx_acc = tx_ready;
            if (bus.mmio_addr == A_TXACK && !bus.mmio_we) found = 1'b1;
        end
        check("rst_txpoll_reached", {31'h0, found}, 32'h1);
        tx_acc = 1'b0;
        reset_mid_cycle("rst_txpoll");
        ack_never = 1'b0;

        // Asynchronous reset during RX_SET
        rx_ready = 1'b0;
        inject(8'h5C);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk); #1;
            if (bus.mmio_we && bus.mmio_addr == A_RXACK && bus.mmio_wdata == 32'h1) found = 1'b1;
        end
        check("rst_rxset_reached", {31'h0, found}, 32'h1);
        check("rst_rxset_valid_before", {31'h0, rx_valid}, 32'h1);
        reset_mid_cycle("rst_rxset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
